// File: rtl/ov7670_frame_scheduler.sv
// Frame scheduler between the OV7670 pixel producer and the ILI9341 consumer.
// Resynchronises vsync/href, decimates frames, gates the display's new-frame strobe and buffers pixels in a FIFO.
module ov7670_frame_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LINE_W     = 10
) (
    input  logic                  clk,
    input  logic                  buttonReset,
    input  logic                  enable,
    input  logic                  vsync,
    input  logic                  href,
    input  logic                  pixelValid,
    input  logic [DATA_WIDTH-1:0] pixelData,
    input  logic [3:0]            frameDivide,
    input  logic                  clearErr,
    output logic                  newFrameStrobe,
    output logic [DATA_WIDTH-1:0] pixelOut,
    output logic                  pixelOutValid,
    input  logic                  pixelOutReady,
    output logic                  frameActive,
    output logic [15:0]           frameCount,
    output logic [LINE_W-1:0]     lineCount,
    output logic                  overflow,
    output logic [7:0]            dropCount,
    output logic [2:0]            stateDbg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_VSYNC = 3'd1,
        STROBE     = 3'd2,
        ACTIVE     = 3'd3,
        SKIP       = 3'd4,
        DRAIN      = 3'd5
    } schedState_t;

    schedState_t state, nextState;

    logic vsMeta, vs, vsPrev, hsMeta, hs, hsPrev;
    logic boundary, hsFall;
    logic [3:0] skipCnt;
    logic passNow, passLatched, decide;
    logic pushReq, drainDrop, push, pop, ovfDrop, anyDrop;
    logic fifoEmpty, fifoFull;
    logic [PW-1:0] wrPtr, rdPtr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Two-flop synchronisers plus one extra stage for edge detection.
    always_ff @(posedge clk or posedge buttonReset) begin
        if (buttonReset) begin
            vsMeta <= 1'b0; vs <= 1'b0; vsPrev <= 1'b0;
            hsMeta <= 1'b0; hs <= 1'b0; hsPrev <= 1'b0;
        end else begin
            vsMeta <= vsync; vs <= vsMeta; vsPrev <= vs;
            hsMeta <= href;  hs <= hsMeta; hsPrev <= hs;
        end
    end

    assign boundary = vs & ~vsPrev;
    assign hsFall   = ~hs & hsPrev;
    assign passNow  = (skipCnt == 4'd0);
    // A decision is consumed only where the FSM acts on it; frameDivide is sampled here.
    assign decide   = boundary & ((state == ACTIVE) |
                      (((state == WAIT_VSYNC) | (state == SKIP)) & enable));

    always_ff @(posedge clk or posedge buttonReset) begin
        if (buttonReset) begin
            skipCnt     <= 4'd0;
            passLatched <= 1'b0;
        end else if (decide) begin
            skipCnt     <= passNow ? frameDivide : skipCnt - 4'd1;
            passLatched <= passNow;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge buttonReset) begin
        if (buttonReset) state <= IDLE;
        else             state <= nextState;
    end

    // FSM: next state
    always_comb begin
        nextState = state;
        case (state)
            IDLE:       if (enable) nextState = WAIT_VSYNC;
            WAIT_VSYNC: begin
                if (!enable)       nextState = IDLE;
                else if (boundary) nextState = passNow ? STROBE : SKIP;
            end
            STROBE:     nextState = ACTIVE;
            ACTIVE:     if (boundary) nextState = DRAIN;
            SKIP: begin
                if (boundary) begin
                    if (!enable) nextState = IDLE;
                    else         nextState = passNow ? STROBE : SKIP;
                end
            end
            DRAIN: begin
                if (fifoEmpty) begin
                    if (!enable) nextState = IDLE;
                    else         nextState = passLatched ? STROBE : SKIP;
                end
            end
            default:    nextState = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        newFrameStrobe = (state == STROBE);
        frameActive    = (state == ACTIVE);
        pushReq        = (state == ACTIVE) & pixelValid & hs & ~vs;
        drainDrop      = (state == DRAIN) & pixelValid;
        stateDbg       = state;
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifoEmpty     = (wrPtr == rdPtr);
    assign fifoFull      = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign pixelOutValid = ~fifoEmpty;
    assign pop           = pixelOutValid & pixelOutReady;
    assign push          = pushReq & (~fifoFull | pop);
    assign ovfDrop       = pushReq & fifoFull & ~pop;
    assign anyDrop       = ovfDrop | drainDrop;
    assign pixelOut      = pixelOutValid ? mem[rdPtr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr[AW-1:0]] <= pixelData;
    end

    always_ff @(posedge clk or posedge buttonReset) begin
        if (buttonReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge buttonReset) begin
        if (buttonReset) begin
            frameCount <= 16'd0;
            lineCount  <= '0;
        end else if (state == STROBE) begin
            frameCount <= frameCount + 16'd1;
            lineCount  <= '0;
        end else if ((state == ACTIVE) && hsFall && (lineCount != '1)) begin
            lineCount  <= lineCount + LINE_W'(1);
        end
    end

    // A drop in the same cycle as clearErr wins over the clear.
    always_ff @(posedge clk or posedge buttonReset) begin
        if (buttonReset) begin
            overflow  <= 1'b0;
            dropCount <= 8'd0;
        end else begin
            if (ovfDrop)       overflow <= 1'b1;
            else if (clearErr) overflow <= 1'b0;

            if (anyDrop) begin
                if (clearErr)                dropCount <= 8'd1;
                else if (dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
            end else if (clearErr) begin
                dropCount <= 8'd0;
            end
        end
    end

endmodule

// File: doc/ov7670_frame_scheduler.md
Name: ov7670_frame_scheduler

Overview:
Sequences the camera-to-TFT pixel path. It sits between OV7670_Ctrl (pixel producer) and ILI9341_8080_I_Driver (pixel consumer). It resynchronises the camera vsync/href, decides which frames are forwarded (frame decimation), and issues the display's new-frame strobe only once the previous frame has drained. Pixels are decoupled through a small FIFO with a valid/ready handshake toward the display.

Parameters:
DATA_WIDTH, 16, pixel width (RGB565)
FIFO_DEPTH, 16, pixel FIFO entries; power of two, minimum 4
LINE_W, 10, width of the line counter

Ports:
clk  in  1  system clock
buttonReset  in  1  asynchronous, active-high reset
enable  in  1  level; run the scheduler
vsync  in  1  raw camera vsync, asynchronous
href  in  1  raw camera href, asynchronous
pixelValid  in  1  one-cycle pulse from OV7670_Ctrl, clk domain
pixelData  in  DATA_WIDTH  pixel accompanying pixelValid
frameDivide  in  4  forward 1 of every frameDivide+1 frames
clearErr  in  1  clears overflow and dropCount
newFrameStrobe  out  1  one-cycle pulse to the display driver
pixelOut  out  DATA_WIDTH  FIFO head
pixelOutValid  out  1  FIFO non-empty
pixelOutReady  in  1  consumer accepts pixelOut this cycle
frameActive  out  1  high in ACTIVE state
frameCount  out  16  forwarded frames, wraps at 0xFFFF→0
lineCount  out  LINE_W  lines completed in the current frame
overflow  out  1  sticky; a push was dropped because the FIFO was full
dropCount  out  8  pixels dropped (overflow or DRAIN), saturates at 255

Behaviour:
- Clock clk; reset buttonReset, asynchronous, active-high.
- Reset state: all outputs 0, FIFO empty, state IDLE, skipCnt 0, synchronisers 0. Reset mid-frame discards FIFO contents immediately.
- vsync and href each pass through a 2-FF synchroniser (vs, hs). Rising and falling edges are detected on the synchronised signals.
- Boundary event: rising edge of vs.
- Decimation decision at each boundary:
  - If skipCnt==0: pass the frame and load skipCnt <= frameDivide.
  - Otherwise: skip the frame and decrement skipCnt.
- State machine:
  - IDLE: enable=1 → WAIT_VSYNC.
  - WAIT_VSYNC: on boundary, a pass decision → STROBE and a skip decision → SKIP. enable=0 → IDLE.
  - STROBE: newFrameStrobe=1 for exactly this cycle, frameCount++, lineCount cleared. Always → ACTIVE next cycle.
  - ACTIVE: push when pixelValid & hs & ~vs. lineCount++ on each hs falling edge. On boundary → DRAIN.
  - SKIP: pixels ignored and not counted as drops. On boundary, apply the decimation decision: pass → STROBE, skip → stay in SKIP. If enable=0 at the boundary → IDLE.
  - DRAIN: pixelValid pulses are dropped and dropCount incremented. When the FIFO is empty, the decimation decision (already latched at the boundary) selects STROBE or SKIP if enable=1, else IDLE.
- Latency: vsync sampled high at edge k → boundary seen at edge k+2 → newFrameStrobe high in the cycle after edge k+2, provided the FIFO is already empty.
- FIFO behaviour:
  - Show-ahead: pixelOut is valid combinationally with pixelOutValid.
  - Pop occurs on pixelOutValid & pixelOutReady.
  - Push latency: pixel visible on pixelOut the cycle after the push when the FIFO was empty.
  - Full with simultaneous push and pop: both are accepted and occupancy is unchanged.
  - Full with push and no pop: the push is dropped, overflow=1, dropCount++.
  - Empty with pop request: cannot occur, because valid is low.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- clearErr clears overflow and dropCount on the next edge. If a drop occurs in the same cycle as clearErr, the drop wins: overflow=1, dropCount=1.
- Counter limits: lineCount saturates at all-ones. dropCount saturates at 255.
- frameDivide is sampled only at boundaries. A change mid-frame affects the next decision only.

Test Plan:
- Reset, enable=1, frameDivide=0, one frame of 4 lines × 8 pixels, pixelOutReady=1 → one newFrameStrobe 3 cycles after vsync rise, 32 pixels out in order, frameCount=1, lineCount=4, overflow=0.
- frameDivide=2, 6 frames → strobes on frames 1 and 4 only, frameCount=2, no pixels output during skipped frames.
- pixelOutReady=0, 20 pixels pushed into FIFO_DEPTH=16 → pixelOutValid=1, overflow=1, dropCount=4. Release ready → exactly 16 pixels emerge, matching the first 16 pushed.
- FIFO full with simultaneous push and pop every cycle for 10 cycles → occupancy stays 16, no drops, output order preserved.
- Hold ready low so 5 pixels remain at the vsync rise; inject 3 pixels during DRAIN → those 3 dropped (dropCount=3), strobe only after the 5th pop, first pixel of the new frame accepted in ACTIVE.
- buttonReset asserted mid-ACTIVE with 7 pixels queued → pixelOutValid=0 and all counters 0 immediately. After release, the scheduler waits in WAIT_VSYNC for the next vsync edge.
